// File: rtl/label_ram_arb.sv
// Label RAM port arbiter: tracks the VGA read address during active video and
// grants round-robin writes from two writers during blanking, capped per window.
module label_ram_arb #(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int MAX_WR = 16
) (
    input  logic          px_clk,
    input  logic          rst,
    input  logic          blank,
    input  logic [AW-1:0] vga_addr,
    input  logic          req0,
    input  logic          req1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] din0,
    input  logic [DW-1:0] din1,
    output logic          ack0,
    output logic          ack1,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    output logic [7:0]    wr_cnt
);

    // state | meaning
    // VIDEO | active video, ram_addr follows vga_addr, no writes
    // IDLE  | blanking, waiting for a request (or cap reached)
    // WRITE | write issued last edge; ram_we drops, count advances
    typedef enum logic [1:0] {VIDEO, IDLE, WRITE} state_t;

    localparam logic [7:0] MAX_WR_C = 8'(MAX_WR);

    state_t        state, state_nxt;
    logic          last_grant, last_nxt;
    logic          grant1;
    logic [AW-1:0] addr_nxt;
    logic [DW-1:0] din_nxt;
    logic          we_nxt, ack0_nxt, ack1_nxt;
    logic [7:0]    cnt_nxt;

    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            state      <= VIDEO;
            last_grant <= 1'b1;
            ram_addr   <= '0;
            ram_din    <= '0;
            ram_we     <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            wr_cnt     <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_nxt;
            ram_addr   <= addr_nxt;
            ram_din    <= din_nxt;
            ram_we     <= we_nxt;
            ack0       <= ack0_nxt;
            ack1       <= ack1_nxt;
            wr_cnt     <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last_grant;
        addr_nxt  = ram_addr;
        din_nxt   = ram_din;
        we_nxt    = 1'b0;
        ack0_nxt  = 1'b0;
        ack1_nxt  = 1'b0;
        cnt_nxt   = wr_cnt;
        // writer 1 wins when alone or when writer 0 held the last grant
        grant1    = req1 && (!req0 || !last_grant);

        case (state)
            VIDEO: begin
                addr_nxt = vga_addr;
                if (blank) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            IDLE: begin
                if (!blank) begin
                    state_nxt = VIDEO;
                    addr_nxt  = vga_addr;
                end else if ((wr_cnt < MAX_WR_C) && (req0 || req1)) begin
                    state_nxt = WRITE;
                    we_nxt    = 1'b1;
                    if (grant1) begin
                        addr_nxt = addr1;
                        din_nxt  = din1;
                        ack1_nxt = 1'b1;
                        last_nxt = 1'b1;
                    end else begin
                        addr_nxt = addr0;
                        din_nxt  = din0;
                        ack0_nxt = 1'b1;
                        last_nxt = 1'b0;
                    end
                end
            end
            WRITE: begin
                if (wr_cnt < MAX_WR_C)
                    cnt_nxt = wr_cnt + 8'd1;
                // leaving for VIDEO reloads the read address so the first video cycle is valid
                if (blank) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = VIDEO;
                    addr_nxt  = vga_addr;
                end
            end
            default: state_nxt = VIDEO;
        endcase
    end

endmodule

// File: tb/tb_label_ram_arb.sv
// Directed bench for label_ram_arb: video tracking, single and round-robin grants,
// write cap, blank falling mid-write and in IDLE, and async reset during a grant.
module tb_label_ram_arb;

    logic       px_clk = 1'b0;
    logic       rst;
    logic       blank;
    logic [7:0] vga_addr;
    logic       req0, req1;
    logic [7:0] addr0, addr1, din0, din1;
    logic       ack0, ack1;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_din;
    logic [7:0] wr_cnt;

    int checks = 0;
    int errors = 0;

    label_ram_arb #(.AW(8), .DW(8), .MAX_WR(16)) dut (
        .px_clk   (px_clk),
        .rst      (rst),
        .blank    (blank),
        .vga_addr (vga_addr),
        .req0     (req0),
        .req1     (req1),
        .addr0    (addr0),
        .addr1    (addr1),
        .din0     (din0),
        .din1     (din1),
        .ack0     (ack0),
        .ack1     (ack1),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_din  (ram_din),
        .wr_cnt   (wr_cnt)
    );

    always #5 px_clk = ~px_clk;

    task automatic tick();
        @(posedge px_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_we"},   8'(ram_we), 8'h0);
        chk({tag, "_ack0"}, 8'(ack0),   8'h0);
        chk({tag, "_ack1"}, 8'(ack1),   8'h0);
    endtask

    initial begin
        rst = 1'b1; blank = 1'b0; vga_addr = 8'h00;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = 8'h00; addr1 = 8'h00; din0 = 8'h00; din1 = 8'h00;

        // reset values
        #3;
        chk("rst_addr", ram_addr, 8'h00);
        chk("rst_din",  ram_din,  8'h00);
        chk("rst_cnt",  wr_cnt,   8'h00);
        chk_idle_outputs("rst");
        tick();
        rst = 1'b0;

        // video tracking with a pending request that must be ignored
        req0 = 1'b1; addr0 = 8'h3C; din0 = 8'h41;
        for (int v = 0; v <= 16; v++) begin
            vga_addr = 8'(v);
            tick();
            chk("vid_addr", ram_addr, 8'(v));
            chk_idle_outputs("vid");
        end

        // blank rises: one write from writer 0, two cycles later
        blank = 1'b1;
        tick();
        chk_idle_outputs("s34_idle");
        chk("s34_cnt0", wr_cnt, 8'h00);
        tick();
        chk("s34_we",   8'(ram_we), 8'h1);
        chk("s34_addr", ram_addr,   8'h3C);
        chk("s34_din",  ram_din,    8'h41);
        chk("s34_ack0", 8'(ack0),   8'h1);
        chk("s34_ack1", 8'(ack1),   8'h0);
        req0 = 1'b0;
        tick();
        chk_idle_outputs("s34_after");
        chk("s34_cnt1", wr_cnt, 8'h01);

        // fresh reset, then both writers held: alternating grants capped at 16
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        addr0 = 8'h10; din0 = 8'hA0; addr1 = 8'h20; din1 = 8'hB0;
        req0 = 1'b1; req1 = 1'b1; blank = 1'b1;
        tick();
        for (int g = 0; g < 16; g++) begin
            tick();
            chk("rr_we",   8'(ram_we), 8'h1);
            chk("rr_ack0", 8'(ack0),   (g % 2 == 0) ? 8'h1 : 8'h0);
            chk("rr_ack1", 8'(ack1),   (g % 2 == 0) ? 8'h0 : 8'h1);
            chk("rr_addr", ram_addr,   (g % 2 == 0) ? 8'h10 : 8'h20);
            chk("rr_din",  ram_din,    (g % 2 == 0) ? 8'hA0 : 8'hB0);
            chk("rr_cntw", wr_cnt,     8'(g));
            tick();
            chk("rr_we0",  8'(ram_we), 8'h0);
            chk("rr_cnti", wr_cnt,     8'(g + 1));
        end
        tick();
        chk_idle_outputs("cap1");
        chk("cap_cnt1", wr_cnt, 8'd16);
        tick();
        chk_idle_outputs("cap2");
        chk("cap_cnt2", wr_cnt, 8'd16);

        // writer 1 granted, blank falls during WRITE
        blank = 1'b0;
        tick();
        blank = 1'b1; req0 = 1'b0;
        tick();
        chk("s36_cnt0", wr_cnt, 8'h00);
        tick();
        chk("s36_ack1", 8'(ack1),   8'h1);
        chk("s36_we",   8'(ram_we), 8'h1);
        chk("s36_addr", ram_addr,   8'h20);
        blank = 1'b0; vga_addr = 8'h55;
        tick();
        chk_idle_outputs("s36_vid");
        chk("s36_vaddr", ram_addr, 8'h55);
        chk("s36_cnt1",  wr_cnt,   8'h01);
        vga_addr = 8'h56;
        tick();
        chk("s36_vaddr2", ram_addr, 8'h56);

        // blank falls in IDLE with req0 pending: no grant until the next window
        req1 = 1'b0; addr0 = 8'h3C; din0 = 8'h41;
        blank = 1'b1;
        tick();
        chk("s37_cnt0", wr_cnt, 8'h00);
        blank = 1'b0; req0 = 1'b1; vga_addr = 8'h77;
        tick();
        chk_idle_outputs("s37_fall");
        chk("s37_vaddr", ram_addr, 8'h77);
        tick();
        chk_idle_outputs("s37_vid");
        blank = 1'b1;
        tick();
        chk("s37_cntr", wr_cnt, 8'h00);
        chk_idle_outputs("s37_idle");
        tick();
        chk("s37_ack0", 8'(ack0),   8'h1);
        chk("s37_addr", ram_addr,   8'h3C);
        chk("s37_din",  ram_din,    8'h41);
        tick();
        chk("s37_cnt1", wr_cnt, 8'h01);

        // last grant was writer 0, so a tie goes to writer 1
        req1 = 1'b1;
        tick();
        chk("s38_ack1", 8'(ack1), 8'h1);
        chk("s38_ack0", 8'(ack0), 8'h0);
        tick();
        chk("s38_cnt2", wr_cnt, 8'h02);
        tick();
        chk("s38_ack0g", 8'(ack0), 8'h1);

        // async reset in the grant cycle
        #2 rst = 1'b1;
        #1;
        chk("s38_rst_addr", ram_addr, 8'h00);
        chk("s38_rst_din",  ram_din,  8'h00);
        chk("s38_rst_cnt",  wr_cnt,   8'h00);
        chk_idle_outputs("s38_rst");
        tick();
        chk_idle_outputs("s38_rsth");
        rst = 1'b0;
        tick();
        chk_idle_outputs("s38_idle");
        tick();
        chk("s38_tie_ack0", 8'(ack0), 8'h1);
        chk("s38_tie_ack1", 8'(ack1), 8'h0);
        chk("s38_tie_addr", ram_addr, 8'h3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
